// File: rtl/di_na_wb_arbiter.sv
// Round-robin arbiter that lets NUM_REQ Wishbone write requesters share one NI port.
// Each grant holds for a whole packet. The arbiter raises an error pulse on an ack timeout.

module di_na_wb_arbiter_lane #(
    parameter int DW = 32
) (
    input  logic          sel,
    input  logic [31:0]   adr,
    input  logic [DW-1:0] dat,
    input  logic          stb,
    input  logic          cyc,
    input  logic          wb_ack,
    input  logic          wb_err,
    input  logic          tmo,
    output logic          s_ack,
    output logic          s_err,
    output logic [DW+33:0] m_req
);
    // Each lane contributes to the shared bus only while it holds the grant, so the
    // top level can combine all lanes with a plain OR.
    assign s_ack = sel & wb_ack;
    assign s_err = sel & (wb_err | tmo);
    assign m_req = sel ? {adr, dat, stb, cyc} : '0;
endmodule

module di_na_wb_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int TIMEOUT        = 255,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req,
    output logic [NUM_REQ-1:0]                  enable,
    input  logic [NUM_REQ*32-1:0]               s_adr_i,
    input  logic [NUM_REQ*NOC_FLIT_WIDTH-1:0]   s_dat_i,
    input  logic [NUM_REQ-1:0]                  s_stb_i,
    input  logic [NUM_REQ-1:0]                  s_cyc_i,
    output logic [NUM_REQ-1:0]                  s_ack_o,
    output logic [NUM_REQ-1:0]                  s_err_o,
    output logic [31:0]                         wb_adr_o,
    output logic [NOC_FLIT_WIDTH-1:0]           wb_dat_o,
    output logic                                wb_stb_o,
    output logic                                wb_cyc_o,
    input  logic                                wb_ack_i,
    input  logic                                wb_err_i,
    output logic [GW-1:0]                       grant_id
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    typedef struct packed {
        logic [31:0]               adr;
        logic [NOC_FLIT_WIDTH-1:0] dat;
        logic                      stb;
        logic                      cyc;
    } wb_req_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] next_id;
    logic [GW-1:0] cand;
    logic          found;
    logic          armed;
    logic [15:0]   tcnt;
    logic [15:0]   tcnt_nxt;
    logic          stall;
    logic          tmo;
    logic          dropping;
    wb_req_t       lane_req [NUM_REQ];
    wb_req_t       m_req;

    // Search upward from the requester after last_grant, wrapping modulo NUM_REQ.
    always_comb begin
        next_id = last_grant;
        found   = 1'b0;
        cand    = last_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(cand) == NUM_REQ - 1) ? '0 : cand + GW'(1);
            if (!found && req[cand]) begin
                found   = 1'b1;
                next_id = cand;
            end
        end
    end

    assign dropping = (state == GRANT) && !req[grant_id];
    assign stall    = (state == GRANT) && wb_stb_o && wb_cyc_o && !wb_ack_i;
    // The pulse fires on the stalled cycle that brings the stall count up to TIMEOUT.
    assign tmo      = stall && (({1'b0, tcnt} + 17'd1) == 17'(TIMEOUT));

    always_comb begin
        tcnt_nxt = tcnt + 16'd1;
        if (!stall || tmo || dropping)
            tcnt_nxt = '0;
    end

    // armed gates the first grant out to the second edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant_id   <= '0;
            enable     <= '0;
            armed      <= 1'b0;
            tcnt       <= '0;
        end else begin
            armed <= 1'b1;
            tcnt  <= tcnt_nxt;
            case (state)
                IDLE: begin
                    if (armed && found) begin
                        state      <= GRANT;
                        grant_id   <= next_id;
                        last_grant <= next_id;
                        enable     <= NUM_REQ'(1) << next_id;
                    end
                end
                GRANT: begin
                    if (dropping) begin
                        state  <= RELEASE;
                        enable <= '0;
                    end
                end
                RELEASE: state <= IDLE;
                default: begin
                    state  <= IDLE;
                    enable <= '0;
                end
            endcase
        end
    end

    // enable doubles as the per-lane select, so reset clears the bus without a clock edge.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        di_na_wb_arbiter_lane #(.DW(NOC_FLIT_WIDTH)) u_lane (
            .sel    (enable[k]),
            .adr    (s_adr_i[k*32 +: 32]),
            .dat    (s_dat_i[k*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH]),
            .stb    (s_stb_i[k]),
            .cyc    (s_cyc_i[k]),
            .wb_ack (wb_ack_i),
            .wb_err (wb_err_i),
            .tmo    (tmo),
            .s_ack  (s_ack_o[k]),
            .s_err  (s_err_o[k]),
            .m_req  (lane_req[k])
        );
    end

    always_comb begin
        m_req = '0;
        for (int k = 0; k < NUM_REQ; k++)
            m_req = wb_req_t'(m_req | lane_req[k]);
    end

    assign wb_adr_o = m_req.adr;
    assign wb_dat_o = m_req.dat;
    assign wb_stb_o = m_req.stb;
    assign wb_cyc_o = m_req.cyc;
endmodule

// File: tb/tb_di_na_wb_arbiter.sv
// Directed bench for di_na_wb_arbiter: the bench acts as a zero-wait slave.
// Expected bus writes are queued as they are driven and retired on each observed ack.

module tb_di_na_wb_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    enable;
    logic [N*32-1:0] s_adr_i;
    logic [N*DW-1:0] s_dat_i;
    logic [N-1:0]    s_stb_i, s_cyc_i, s_ack_o, s_err_o;
    logic [31:0]     wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i;
    logic [0:0]      grant_id;

    typedef struct {
        int          id;
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   idle;

    di_na_wb_arbiter #(.NUM_REQ(N), .NOC_FLIT_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .enable(enable),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
        .s_ack_o(s_ack_o), .s_err_o(s_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each acked bus beat retires the oldest expected write.
    always @(negedge clk) begin
        if (wb_stb_o && wb_cyc_o && wb_ack_i) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected_ack: observed adr %0h expected no transfer", wb_adr_o);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("sb_grant_id", 64'(grant_id), 64'(mon_e.id));
                chk("sb_adr", 64'(wb_adr_o), 64'(mon_e.adr));
                chk("sb_dat", 64'(wb_dat_o), 64'(mon_e.dat));
                chk("sb_ack_route", 64'(s_ack_o), 64'(1) << mon_e.id);
            end
        end
    end

    task automatic wait_grant(input int k, output int idl);
        idl = 0;
        for (int i = 0; i < 20; i++) begin
            if (enable[k]) break;
            if (!wb_cyc_o) idl++;
            tick();
        end
        chk($sformatf("grant_%0d", k), 64'(enable), 64'(1) << k);
    endtask

    // Zero-wait packet of n beats; req[k] drops together with the final ack.
    task automatic packet(input int k, input logic [31:0] a0, input logic [31:0] d0, input int n);
        for (int b = 0; b < n; b++) begin
            s_adr_i[k*32 +: 32] = a0 + 32'(b * 4);
            s_dat_i[k*32 +: 32] = d0 + 32'(b);
            s_stb_i[k] = 1'b1;
            s_cyc_i[k] = 1'b1;
            wb_ack_i   = 1'b1;
            if (b == n - 1) req[k] = 1'b0;
            sb.push_back(exp_t'{k, a0 + 32'(b * 4), d0 + 32'(b)});
            tick();
        end
        // RELEASE: requester is still strobing but the bus must be quiet.
        chk("rel_enable", 64'(enable), 64'(0));
        chk("rel_stb_cyc", 64'({wb_stb_o, wb_cyc_o}), 64'(0));
        chk("rel_adr", 64'(wb_adr_o), 64'(0));
        s_stb_i[k] = 1'b0;
        s_cyc_i[k] = 1'b0;
        wb_ack_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; s_adr_i = '0; s_dat_i = '0;
        s_stb_i = '0; s_cyc_i = '0; wb_ack_i = 1'b1; wb_err_i = 1'b1;

        // Reset state with requests and slave responses already active.
        req = 2'b01;
        s_adr_i[63:32] = 32'hB000_0020;
        s_stb_i = 2'b11; s_cyc_i = 2'b11;
        repeat (3) tick();
        chk("rst_enable", 64'(enable), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_stb_cyc", 64'({wb_stb_o, wb_cyc_o}), 64'(0));
        chk("rst_adr", 64'(wb_adr_o), 64'(0));
        chk("rst_ack_err", 64'({s_ack_o, s_err_o}), 64'(0));
        s_stb_i = '0; s_cyc_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

        // Single request: no grant on the first edge after release, grant on the second.
        rst_n = 1'b1;
        tick();
        chk("arm_edge1", 64'(enable), 64'(0));
        tick();
        chk("first_grant", 64'(enable), 64'(2'b01));
        chk("first_gid", 64'(grant_id), 64'(0));
        packet(0, 32'hA000_0010, 32'h1111_0001, 2);

        // Round robin 0,1,0 with both requesting.
        rst_n = 1'b0; req = 2'b11;
        tick();
        rst_n = 1'b1;
        wait_grant(0, idle);
        packet(0, 32'h0000_1000, 32'h2222_0000, 3);
        wait_grant(1, idle);
        chk("rr_idle_0to1", 64'(idle), 64'(2));
        chk("rr_gid1", 64'(grant_id), 64'(1));
        req[0] = 1'b1;
        tick();
        chk("no_preempt", 64'(enable), 64'(2'b10));
        packet(1, 32'h0000_2000, 32'h3333_0000, 3);
        wait_grant(0, idle);
        chk("rr_idle_1to0", 64'(idle), 64'(2));
        chk("rr_gid0", 64'(grant_id), 64'(0));
        packet(0, 32'h0000_3000, 32'h4444_0000, 3);

        // Timeout: requester 1 stalls; error pulses on stalled cycles 4 and 8.
        req[1] = 1'b1;
        wait_grant(1, idle);
        s_adr_i[63:32] = 32'hC000_0000;
        s_stb_i[1] = 1'b1; s_cyc_i[1] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("tmo_err_c%0d", i + 1), 64'(s_err_o),
                64'((i == 3 || i == 7) ? 2'b10 : 2'b00));
            chk("tmo_enable_held", 64'(enable), 64'(2'b10));
            tick();
        end

        // Error pass-through for requester 1.
        wb_err_i = 1'b1;
        #1;
        chk("err_pass", 64'(s_err_o), 64'(2'b10));
        chk("err_no_ack", 64'(s_ack_o), 64'(0));
        tick();
        wb_err_i = 1'b0;
        packet(1, 32'hC000_0000, 32'h5555_0000, 1);

        // Asynchronous reset mid-transfer, then requester 1 alone wins.
        req[0] = 1'b1;
        wait_grant(0, idle);
        s_stb_i[0] = 1'b1; s_cyc_i[0] = 1'b1;
        #1;
        chk("pre_rst_stb_cyc", 64'({wb_stb_o, wb_cyc_o}), 64'(2'b11));
        #1 rst_n = 1'b0;
        #1;
        chk("async_stb_cyc", 64'({wb_stb_o, wb_cyc_o}), 64'(0));
        chk("async_enable", 64'(enable), 64'(0));
        chk("async_gid", 64'(grant_id), 64'(0));
        s_stb_i = '0; s_cyc_i = '0; req = 2'b10;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_edge1", 64'(enable), 64'(0));
        wait_grant(1, idle);
        chk("post_rst_gid", 64'(grant_id), 64'(1));
        packet(1, 32'hD000_0000, 32'h6666_0000, 2);

        repeat (3) tick();
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
